// File: rtl/coord_motion_sequencer_pkg.sv
// Shared definitions for the coordinate motion sequencer.
//   - coordinate word field positions and a word builder
//   - 16-entry preset (x,y) seed table
//   - FSM state encoding
package coord_motion_sequencer_pkg;

    localparam int unsigned COORD_W    = 10;
    localparam int unsigned ENABLE_BIT = 29;
    localparam int unsigned X_LSB      = 19;
    localparam int unsigned Y_LSB      = 9;
    localparam int unsigned CH_LSB     = 0;

    typedef enum logic [1:0] {
        StLoad,
        StEmit,
        StIdle,
        StUpdate
    } state_e;

    localparam logic [COORD_W-1:0] PRESET_X [16] = '{
        10'd50,  10'd50,  10'd590, 10'd590, 10'd320, 10'd100, 10'd150, 10'd520,
        10'd234, 10'd250, 10'd73,  10'd99,  10'd200, 10'd111, 10'd433, 10'd400
    };

    localparam logic [COORD_W-1:0] PRESET_Y [16] = '{
        10'd50,  10'd430, 10'd50,  10'd430, 10'd240, 10'd100, 10'd200, 10'd400,
        10'd300, 10'd450, 10'd73,  10'd100, 10'd130, 10'd344, 10'd123, 10'd230
    };

    // {2'b00, enable, x[9:0], y[9:0], channel zero-extended to 9 bits}
    function automatic logic [31:0] make_word(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y,
                                              input logic [3:0]         ch);
        logic [31:0] w;
        w                         = '0;
        w[ENABLE_BIT]             = 1'b1;
        w[X_LSB +: COORD_W]       = x;
        w[Y_LSB +: COORD_W]       = y;
        w[CH_LSB +: 4]            = ch;
        return w;
    endfunction

endpackage

// File: rtl/coord_motion_sequencer_if.sv
// Valid/ready coordinate word stream towards the GPU instruction path.
//   valid  word/channel are valid this cycle (master -> slave)
//   ready  slave accepts the word this cycle (slave -> master)
//   data   32-bit coordinate word
//   ch     channel index of data
interface coord_motion_sequencer_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [3:0]  ch;

    modport master (output valid, output data, output ch, input ready);
    modport slave  (input valid, input data, input ch, output ready);
endinterface

// File: rtl/coord_motion_sequencer_axis.sv
// One axis step with clamp and bounce (combinational).
//   p       current position (unsigned, W bits)
//   d       current signed velocity
//   p_next  stepped position, clamped to [MIN, MAX]
//   d_next  velocity, negated when a limit was crossed
module coord_axis_step #(
    parameter int unsigned W   = 10,
    parameter int          MIN = 0,
    parameter int          MAX = 639
) (
    input  logic [W-1:0]       p,
    input  logic signed [7:0]  d,
    output logic [W-1:0]       p_next,
    output logic signed [7:0]  d_next
);

    localparam logic signed [W+1:0] MinS = (W+2)'(MIN);
    localparam logic signed [W+1:0] MaxS = (W+2)'(MAX);

    // Two guard bits keep the sum exact for both overshoot directions.
    logic signed [W+1:0] n;

    always_comb begin
        n      = $signed({2'b00, p}) + $signed({{(W-6){d[7]}}, d});
        p_next = n[W-1:0];
        d_next = d;
        if (n > MaxS) begin
            p_next = MaxS[W-1:0];
            d_next = -d;
        end else if (n < MinS) begin
            p_next = MinS[W-1:0];
            d_next = -d;
        end
    end

endmodule

// File: rtl/coord_motion_sequencer.sv
// Sprite coordinate sequencer: seeds N_CH channels from a preset table, optionally
// moves them once per frame tick with bouncing, and streams one word per channel.
//   clk, reset   clock, synchronous active-high reset
//   switch       preset selector; change while idle reloads
//   mode         0 = re-emit unchanged, 1 = step then emit (sampled in idle)
//   frame_tick   one pulse per video frame
//   out          coordinate word stream (master)
//   busy         high while loading, updating or emitting
//   overrun_cnt  frame ticks lost while one was already pending, saturating
module coord_motion_sequencer
    import coord_motion_sequencer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int STEP  = 4,
    parameter int X_MIN = 0,
    parameter int X_MAX = 639,
    parameter int Y_MIN = 0,
    parameter int Y_MAX = 479
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 switch,
    input  logic                       mode,
    input  logic                       frame_tick,
    coord_motion_sequencer_if.master   out,
    output logic                       busy,
    output logic [7:0]                 overrun_cnt
);

    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N_CH - 1);
    localparam logic signed [7:0] StepS = 8'(STEP);

    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, idx_nxt;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    ch_q, ch_d;
    logic          pend_q, pend_d;
    logic [7:0]    ovr_q, ovr_d;
    logic          busy_q;
    logic [3:0]    sw_lat_q;

    logic [COORD_W-1:0] px_q [N_CH];
    logic [COORD_W-1:0] py_q [N_CH];
    logic signed [7:0]  dx_q [N_CH];
    logic signed [7:0]  dy_q [N_CH];
    logic [COORD_W-1:0] px_n [N_CH];
    logic [COORD_W-1:0] py_n [N_CH];
    logic signed [7:0]  dx_n [N_CH];
    logic signed [7:0]  dy_n [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        coord_axis_step #(.W(COORD_W), .MIN(X_MIN), .MAX(X_MAX)) u_x (
            .p      (px_q[c]),
            .d      (dx_q[c]),
            .p_next (px_n[c]),
            .d_next (dx_n[c])
        );
        coord_axis_step #(.W(COORD_W), .MIN(Y_MIN), .MAX(Y_MAX)) u_y (
            .p      (py_q[c]),
            .d      (dy_q[c]),
            .p_next (py_n[c]),
            .d_next (dy_n[c])
        );
    end

    assign idx_nxt = IW'(idx_q + 1'b1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            StLoad, StUpdate: begin
                state_d = StEmit;
                idx_d   = '0;
            end
            StEmit: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = make_word(px_q[idx_q], py_q[idx_q], 4'(idx_q));
                    ch_d    = 4'(idx_q);
                end else if (out.ready) begin
                    if (idx_q == LastIdx) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = make_word(px_q[idx_nxt], py_q[idx_nxt], 4'(idx_nxt));
                        ch_d   = 4'(idx_nxt);
                    end
                end
            end
            StIdle: begin
                if (switch != sw_lat_q) begin
                    state_d = StLoad;
                end else if (frame_tick || pend_q) begin
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    state_d = mode ? StUpdate : StEmit;
                end
            end
            default: state_d = StLoad;
        endcase

        // A tick not consumed this cycle (busy, or pre-empted by a reload) is queued.
        if (frame_tick && ((state_q != StIdle) || (switch != sw_lat_q))) begin
            if (pend_q) begin
                if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StLoad;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ch_q     <= '0;
            pend_q   <= 1'b0;
            ovr_q    <= '0;
            busy_q   <= 1'b0;
            sw_lat_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != StIdle);
            if (state_q == StLoad) sw_lat_q <= switch;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (state_q == StLoad) begin
                px_q[c] <= PRESET_X[switch + 4'(c)];
                py_q[c] <= PRESET_Y[switch + 4'(c)];
                dx_q[c] <= (c % 2 == 0) ? StepS : -StepS;
                dy_q[c] <= (c % 4 < 2) ? StepS : -StepS;
            end else if (state_q == StUpdate) begin
                px_q[c] <= px_n[c];
                py_q[c] <= py_n[c];
                dx_q[c] <= dx_n[c];
                dy_q[c] <= dy_n[c];
            end
        end
    end

    assign out.valid   = valid_q;
    assign out.data    = data_q;
    assign out.ch      = ch_q;
    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_coord_motion_sequencer.sv
// Self-checking bench for coord_motion_sequencer (N_CH=4, STEP=4, 640x480 limits).
module tb_coord_motion_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       mode;
    logic       tick;
    logic       busy;
    logic [7:0] ovr;

    coord_motion_sequencer_if bus ();

    coord_motion_sequencer #(
        .N_CH(4), .STEP(4), .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .switch      (sw),
        .mode        (mode),
        .frame_tick  (tick),
        .out         (bus),
        .busy        (busy),
        .overrun_cnt (ovr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] last_word [4];

    int px_tab [16] = '{50, 50, 590, 590, 320, 100, 150, 520,
                        234, 250, 73, 99, 200, 111, 433, 400};
    int py_tab [16] = '{50, 430, 50, 430, 240, 100, 200, 400,
                        300, 450, 73, 100, 130, 344, 123, 230};
    int mx [4];
    int my [4];
    int mdx [4];
    int mdy [4];

    function automatic logic [31:0] model_word(input int x, input int y, input int c);
        return {2'b00, 1'b1, 10'(x), 10'(y), 9'(c)};
    endfunction

    task automatic model_seed(input int s);
        for (int c = 0; c < 4; c++) begin
            mx[c]  = px_tab[(s + c) % 16];
            my[c]  = py_tab[(s + c) % 16];
            mdx[c] = (c % 2 == 0) ? 4 : -4;
            mdy[c] = (c % 4 < 2) ? 4 : -4;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 4; c++) begin
            int n;
            n = mx[c] + mdx[c];
            if (n > 639) begin mx[c] = 639; mdx[c] = -mdx[c]; end
            else if (n < 0) begin mx[c] = 0; mdx[c] = -mdx[c]; end
            else mx[c] = n;
            n = my[c] + mdy[c];
            if (n > 479) begin my[c] = 479; mdy[c] = -mdy[c]; end
            else if (n < 0) begin my[c] = 0; mdy[c] = -mdy[c]; end
            else my[c] = n;
        end
    endtask

    task automatic push_frame();
        for (int c = 0; c < 4; c++) exp_q.push_back(model_word(mx[c], my[c], c));
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Pops the scoreboard on every handshake seen at a negedge (transfer at next posedge).
    task automatic collect(input int n, input string name, input bit tail);
        int got = 0;
        int cyc = 0;
        logic [31:0] e;
        while (got < n && cyc < 300) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (bus.valid && bus.ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s unexpected word data=%h ch=%0d", name, bus.data, bus.ch);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.data !== e || bus.ch !== e[3:0]) begin
                        bad++;
                        $display("FAIL %s word %0d: got data=%h ch=%0d, want data=%h ch=%0d",
                                 name, got, bus.data, bus.ch, e, e[3:0]);
                    end
                end
                last_word[bus.ch[1:0]] = bus.data;
                got++;
            end
        end
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d words, want %0d", name, got, n);
        end
        if (tail) repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; sw = 4'd0; mode = 1'b0; tick = 1'b0; bus.ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rst valid got=%b want=0", bus.valid); end
        total++; if (bus.data !== 32'h0) begin bad++; $display("FAIL rst data got=%h want=0", bus.data); end
        total++; if (bus.ch !== 4'h0) begin bad++; $display("FAIL rst ch got=%0d want=0", bus.ch); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst busy got=%b want=0", busy); end
        total++; if (ovr !== 8'h0) begin bad++; $display("FAIL rst overrun got=%0d want=0", ovr); end
        reset = 1'b0;
        exp_q.push_back(32'h21906400);
        exp_q.push_back(32'h21935C01);
        exp_q.push_back(32'h32706402);
        exp_q.push_back(32'h32735C03);
        model_seed(0);
        collect(4, "reset_frame", 1'b1);
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL post_frame valid got=%b want=0", bus.valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_frame busy got=%b want=0", busy); end
    endtask

    task automatic test_motion();
        mode = 1'b1;
        pulse_tick();
        model_step();
        push_frame();
        collect(4, "motion_tick1", 1'b1);
        total++;
        if (last_word[0] !== 32'h21B06C00) begin
            bad++; $display("FAIL motion ch0 got=%h want=21b06c00", last_word[0]);
        end
    endtask

    task automatic test_bounce();
        for (int t = 2; t <= 13; t++) begin
            pulse_tick();
            model_step();
            push_frame();
            collect(4, "bounce_tick", 1'b1);
        end
        total++;
        if (last_word[2][28:19] !== 10'd639) begin
            bad++; $display("FAIL bounce13 ch2 x got=%0d want=639", last_word[2][28:19]);
        end
        pulse_tick();
        model_step();
        push_frame();
        collect(4, "bounce_tick14", 1'b1);
        total++;
        if (last_word[2][28:19] !== 10'd635) begin
            bad++; $display("FAIL bounce14 ch2 x got=%0d want=635", last_word[2][28:19]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        pulse_tick();
        model_step();
        push_frame();
        collect(1, "bp_ch0", 1'b0);
        @(negedge clk);
        bus.ready = 1'b0;
        held = bus.data;
        total++;
        if (bus.ch !== 4'd1 || bus.valid !== 1'b1) begin
            bad++; $display("FAIL bp stall ch got=%0d valid=%b want ch=1 valid=1", bus.ch, bus.valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick = (i == 2 || i == 5);
            @(negedge clk);
            total++;
            if (bus.data !== held || bus.ch !== 4'd1 || bus.valid !== 1'b1) begin
                bad++; $display("FAIL bp hold cycle %0d got=%h/%0d want=%h/1", i, bus.data, bus.ch, held);
            end
        end
        tick = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp busy got=%b want=1", busy); end
        total++; if (ovr !== 8'd1) begin bad++; $display("FAIL bp overrun got=%0d want=1", ovr); end
        bus.ready = 1'b1;
        model_step();
        push_frame();
        collect(7, "bp_release", 1'b1);
        repeat (5) @(negedge clk);
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL bp extra frame valid got=%b want=0", bus.valid); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_switch_load();
        sw = 4'd4;
        model_seed(4);
        push_frame();
        collect(4, "switch_load", 1'b1);
        total++;
        if (last_word[0] !== 32'h2A01E000) begin
            bad++; $display("FAIL switch ch0 got=%h want=2a01e000", last_word[0]);
        end
    endtask

    task automatic test_static();
        mode = 1'b0;
        pulse_tick();
        push_frame();
        collect(4, "static_reemit", 1'b1);
        // Reload and tick together: reload frame first, then the pending static re-emit.
        sw = 4'd0;
        pulse_tick();
        model_seed(0);
        push_frame();
        push_frame();
        collect(8, "load_plus_tick", 1'b1);
    endtask

    task automatic test_reset_mid_emit();
        bit seen = 1'b0;
        pulse_tick();
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.valid && bus.ch == 4'd1) seen = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_emit never reached ch1 got=0 want=1"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL mid_emit valid got=%b want=0", bus.valid); end
        total++; if (ovr !== 8'd0) begin bad++; $display("FAIL mid_emit overrun got=%0d want=0", ovr); end
        model_seed(0);
        push_frame();
        collect(4, "mid_emit_reseed", 1'b1);
    endtask

    initial begin
        reset = 1'b1; sw = 4'd0; mode = 1'b0; tick = 1'b0; bus.ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_motion();
        test_bounce();
        test_backpressure();
        test_switch_load();
        test_static();
        test_reset_mid_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
